// File: rtl/systolic_is_ctrl.sv
// Job sequencer for an NxN input-stationary systolic array: optional weight load,
// skewed activation issue, per-column output-valid flags and job completion.
module systolic_is_ctrl #(
    parameter int N       = 4,
    parameter int K_MAX   = 16,
    parameter int OUT_LAT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   k_len,
    input  logic                         reuse_w,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         load_weight,
    output logic                         w_rd_en,
    output logic [$clog2(N)-1:0]         w_rd_addr,
    output logic                         a_rd_en,
    output logic [$clog2(K_MAX)-1:0]     a_rd_addr,
    output logic [N-1:0]                 act_lane_en,
    output logic [N-1:0]                 out_col_valid,
    output logic                         out_last
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int WW = $clog2(N);
    localparam int AW = $clog2(K_MAX);
    localparam int CW = $clog2(K_MAX + N + OUT_LAT + 1);

    localparam logic [KW-1:0] KMAX_K    = KW'(K_MAX);
    localparam logic [CW-1:0] LOAD_LAST = CW'(N);
    localparam logic [CW-1:0] TAIL      = CW'(N - 1 + OUT_LAT);
    localparam logic [CW-1:0] TOP_ROW   = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [KW-1:0]     k_q, k_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              load_weight_q, load_weight_d;
    logic              w_rd_en_q, w_rd_en_d;
    logic [WW-1:0]     w_rd_addr_q, w_rd_addr_d;
    logic              a_rd_en_q, a_rd_en_d;
    logic [AW-1:0]     a_rd_addr_q, a_rd_addr_d;
    logic [N-1:0]      act_lane_en_q, act_lane_en_d;
    logic [N-1:0]      out_col_valid_q, out_col_valid_d;
    logic              out_last_q, out_last_d;

    logic [CW-1:0]     k_ext_q, k_ext_d;
    logic [CW-1:0]     ctot_q, ctot_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        err_d   = 1'b0;
        k_ext_q = CW'(k_q);
        ctot_q  = k_ext_q + TAIL;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    if (k_len == '0 || k_len > KMAX_K) begin
                        err_d = 1'b1;
                    end else begin
                        k_d     = k_len;
                        state_d = reuse_w ? S_COMPUTE : S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LOAD_LAST) begin
                    state_d = S_COMPUTE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COMPUTE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == ctot_q - 1'b1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state/counter so the flopped outputs
    // line up with the state they describe.
    always_comb begin
        busy_d          = (state_d != S_IDLE);
        done_d          = (state_d == S_DONE);
        load_weight_d   = 1'b0;
        w_rd_en_d       = 1'b0;
        w_rd_addr_d     = '0;
        a_rd_en_d       = 1'b0;
        a_rd_addr_d     = '0;
        act_lane_en_d   = '0;
        out_col_valid_d = '0;
        out_last_d      = 1'b0;
        k_ext_d         = CW'(k_d);
        ctot_d          = k_ext_d + TAIL;

        if (state_d == S_LOAD) begin
            w_rd_en_d     = (cnt_d < LOAD_LAST);
            w_rd_addr_d   = w_rd_en_d ? WW'(TOP_ROW - cnt_d) : '0;
            load_weight_d = (cnt_d != '0);
        end

        if (state_d == S_COMPUTE) begin
            a_rd_en_d   = (cnt_d < k_ext_d);
            a_rd_addr_d = a_rd_en_d ? AW'(cnt_d) : '0;
            for (int unsigned r = 0; r < N; r++) begin
                act_lane_en_d[r] = (cnt_d >= CW'(r)) && (cnt_d < CW'(r) + k_ext_d);
            end
            for (int unsigned j = 0; j < N; j++) begin
                out_col_valid_d[j] = (cnt_d >= CW'(j + OUT_LAT)) &&
                                     (cnt_d < CW'(j + OUT_LAT) + k_ext_d);
            end
            out_last_d = (cnt_d == ctot_d - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            k_q             <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            load_weight_q   <= 1'b0;
            w_rd_en_q       <= 1'b0;
            w_rd_addr_q     <= '0;
            a_rd_en_q       <= 1'b0;
            a_rd_addr_q     <= '0;
            act_lane_en_q   <= '0;
            out_col_valid_q <= '0;
            out_last_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            k_q             <= k_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
            load_weight_q   <= load_weight_d;
            w_rd_en_q       <= w_rd_en_d;
            w_rd_addr_q     <= w_rd_addr_d;
            a_rd_en_q       <= a_rd_en_d;
            a_rd_addr_q     <= a_rd_addr_d;
            act_lane_en_q   <= act_lane_en_d;
            out_col_valid_q <= out_col_valid_d;
            out_last_q      <= out_last_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign load_weight   = load_weight_q;
    assign w_rd_en       = w_rd_en_q;
    assign w_rd_addr     = w_rd_addr_q;
    assign a_rd_en       = a_rd_en_q;
    assign a_rd_addr     = a_rd_addr_q;
    assign act_lane_en   = act_lane_en_q;
    assign out_col_valid = out_col_valid_q;
    assign out_last      = out_last_q;

endmodule

// File: tb/tb_systolic_is_ctrl.sv
// Bench for systolic_is_ctrl: directed timing scenarios plus random traffic, each
// cycle compared against a job-timeline reference model.
module tb_systolic_is_ctrl;

    localparam int N       = 4;
    localparam int K_MAX   = 16;
    localparam int OUT_LAT = 4;
    localparam int KW      = $clog2(K_MAX + 1);
    localparam int WW      = $clog2(N);
    localparam int AW      = $clog2(K_MAX);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          reuse_w = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, err, load_weight, w_rd_en, a_rd_en, out_last;
    logic [WW-1:0] w_rd_addr;
    logic [AW-1:0] a_rd_addr;
    logic [N-1:0]  act_lane_en, out_col_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a job is a timeline indexed by elapsed cycles m_e (1 = first busy cycle).
    bit m_act = 0;
    int m_e   = 0;
    int m_k   = 0;
    bit m_reuse = 0;
    bit m_err = 0;

    systolic_is_ctrl #(.N(N), .K_MAX(K_MAX), .OUT_LAT(OUT_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .reuse_w(reuse_w),
        .abort(abort), .busy(busy), .done(done), .err(err), .load_weight(load_weight),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
        .act_lane_en(act_lane_en), .out_col_valid(out_col_valid), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model;
        int L, ctot, endc, c, w;
        logic e_busy, e_done, e_lw, e_wen, e_aen, e_last;
        logic [31:0] e_waddr, e_aaddr;
        logic [N-1:0] e_lane, e_col;
        e_busy = m_act; e_done = 0; e_lw = 0; e_wen = 0; e_aen = 0; e_last = 0;
        e_waddr = 0; e_aaddr = 0; e_lane = '0; e_col = '0;
        if (m_act) begin
            L    = m_reuse ? 0 : N + 1;
            ctot = m_k + N - 1 + OUT_LAT;
            endc = L + ctot + 1;
            if (m_e <= L) begin
                w = m_e - 1;
                e_wen = (w < N);
                e_waddr = e_wen ? N - 1 - w : 0;
                e_lw = (w >= 1);
            end else if (m_e <= L + ctot) begin
                c = m_e - L - 1;
                e_aen = (c < m_k);
                e_aaddr = e_aen ? c : 0;
                for (int r = 0; r < N; r++) e_lane[r] = (c >= r) && (c < r + m_k);
                for (int j = 0; j < N; j++) e_col[j] = (c >= j + OUT_LAT) && (c < j + OUT_LAT + m_k);
                e_last = (c == ctot - 1);
            end else if (m_e == endc) begin
                e_done = 1;
            end
        end
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("err", err, m_err);
        check("load_weight", load_weight, e_lw);
        check("w_rd_en", w_rd_en, e_wen);
        check("w_rd_addr", w_rd_addr, e_waddr);
        check("a_rd_en", a_rd_en, e_aen);
        check("a_rd_addr", a_rd_addr, e_aaddr);
        check("act_lane_en", act_lane_en, e_lane);
        check("out_col_valid", out_col_valid, e_col);
        check("out_last", out_last, e_last);
    endtask

    task automatic model_update(input bit st, input int kl, input bit rw, input bit ab);
        int endc;
        bit was_act;
        was_act = m_act;
        m_err = !was_act && st && (kl == 0 || kl > K_MAX);
        if (!was_act) begin
            if (st && kl >= 1 && kl <= K_MAX) begin
                m_act = 1; m_e = 1; m_k = kl; m_reuse = rw;
            end
        end else begin
            endc = (m_reuse ? 0 : N + 1) + m_k + N - 1 + OUT_LAT + 1;
            if (ab || m_e == endc) m_act = 0;
            else m_e++;
        end
    endtask

    // One cycle: compare this cycle's outputs, then apply inputs for this cycle.
    task automatic step(input bit st, input int kl, input bit rw, input bit ab);
        @(negedge clk);
        check_model();
        start = st; k_len = KW'(kl); reuse_w = rw; abort = ab;
        model_update(st, kl, rw, ab);
    endtask

    task automatic drain;
        for (int i = 0; i < 60 && m_act; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("drain_busy", busy, 0);
    endtask

    task automatic do_reset;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_outs", {busy, done, err, load_weight, w_rd_en, w_rd_addr, a_rd_en,
                           a_rd_addr, act_lane_en, out_col_valid, out_last}, 0);
        start = 0; abort = 0; k_len = '0; reuse_w = 0;
        m_act = 0; m_err = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int first_w, last_c, done_c, lw_cnt, col3_c, second_w;
        bit st, ab;

        repeat (3) @(negedge clk);
        check("rst_init", {busy, done, err, load_weight, w_rd_en, a_rd_en, act_lane_en,
                           out_col_valid, out_last}, 0);
        rst = 1'b1;

        // Full job with weight load, k_len=3
        step(1, 3, 0, 0);
        first_w = -1; last_c = -1; done_c = -1; lw_cnt = 0;
        for (int i = 1; i <= 18; i++) begin
            step(0, 0, 0, 0);
            if (w_rd_en && first_w < 0) first_w = i;
            if (out_last) last_c = i;
            if (done) done_c = i;
            if (load_weight) lw_cnt++;
        end
        check("t2_first_wrd", first_w, 1);
        check("t2_last_cyc", last_c, 15);
        check("t2_done_cyc", done_c, 16);
        check("t2_lw_count", lw_cnt, N);

        // Reuse weights, k_len=1
        step(1, 1, 1, 0);
        col3_c = -1; done_c = -1; lw_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0, 0);
            if (out_col_valid[3]) col3_c = i;
            if (done) done_c = i;
            if (load_weight) lw_cnt++;
        end
        check("t3_col3_cyc", col3_c, 8);
        check("t3_done_cyc", done_c, 9);
        check("t3_lw_count", lw_cnt, 0);

        // Illegal lengths, then the maximum legal length
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("t4_err_k0", {err, busy}, 2'b10);
        step(1, K_MAX + 1, 0, 0);
        step(0, 0, 0, 0);
        check("t4_err_kmax1", {err, busy}, 2'b10);
        step(1, K_MAX, 1, 0);
        drain();

        // Abort at COMPUTE c=5, with an ignored start while busy
        step(1, 8, 1, 0);
        done_c = -1;
        for (int i = 1; i <= 12; i++) begin
            step(i == 3, 2, 0, i == 6);
            if (i == 7) check("t5_abort_busy", busy, 0);
            if (done) done_c = i;
        end
        check("t5_no_done", done_c, -1);

        // Start held high: the next job loads after DONE plus one IDLE cycle
        done_c = -1; second_w = -1;
        step(1, 2, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step(1, 2, 0, 0);
            if (done && done_c < 0) done_c = i;
            if (done_c > 0 && w_rd_en && second_w < 0) second_w = i;
        end
        check("t6_done_cyc", done_c, 15);
        check("t6_second_load", second_w, 17);
        drain();

        // Random traffic with asynchronous resets mid-job
        for (int i = 0; i < 600; i++) begin
            if (i == 200 || i == 450) do_reset();
            st = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 29) == 0);
            step(st, $urandom_range(0, K_MAX + 1), $urandom_range(0, 1) == 1, ab);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
